// File: rtl/riscv_pkg.sv
// Shared integer-core types: data width, register address type, x0 constant.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int BUSY_CNT_W = 6;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/read/writeback bundle between the core pipeline and the register file.
// Latency: reads and stall are combinational, busyCount is registered.
// Backpressure: stall tells the issue stage to hold its current instruction.
interface regfile_sb_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    import riscv_pkg::*;

    reg_addr_t              rs1Addr;
    reg_addr_t              rs2Addr;
    logic                   useRs1;
    logic                   useRs2;
    logic [XLEN-1:0]        r1;
    logic [XLEN-1:0]        r2;
    logic                   we;
    reg_addr_t              rdAddr;
    logic [XLEN-1:0]        rdData;
    logic                   issueValid;
    reg_addr_t              issueRd;
    logic                   stall;
    logic [BUSY_CNT_W-1:0]  busyCount;

    // Core pipeline side.
    modport master (
        output rs1Addr, rs2Addr, useRs1, useRs2,
        output we, rdAddr, rdData,
        output issueValid, issueRd,
        input  r1, r2, stall, busyCount
    );

    // Register file side.
    modport slave (
        input  rs1Addr, rs2Addr, useRs1, useRs2,
        input  we, rdAddr, rdData,
        input  issueValid, issueRd,
        output r1, r2, stall, busyCount
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy bit per register, RAW/WAW stall, busy popcount.
// Latency: stall combinational; busy bits and busyCount update at the next edge.
// Backpressure: an issue that coincides with stall is dropped; the issuer must hold.
module reg_scoreboard import riscv_pkg::*; #(
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  reg_addr_t              rs1Addr,
    input  reg_addr_t              rs2Addr,
    input  logic                   useRs1,
    input  logic                   useRs2,
    input  logic                   we,
    input  reg_addr_t              rdAddr,
    input  logic                   issueValid,
    input  reg_addr_t              issueRd,
    output logic                   stall,
    output logic [BUSY_CNT_W-1:0]  busyCount
);

    logic [NREGS-1:0]       busy;
    logic [NREGS-1:0]       busy_nxt;
    logic [NREGS-1:0]       set_vec;
    logic [NREGS-1:0]       clr_vec;
    logic                   wb_en;
    logic                   raw1;
    logic                   raw2;
    logic                   waw;
    logic                   issue_en;
    logic [BUSY_CNT_W-1:0]  cnt_nxt;

    // Hazard detection; a same-cycle writeback resolves RAW only when it is forwarded,
    // but always resolves WAW because the register is being retired this edge.
    always_comb begin
        wb_en    = we && (rdAddr != REG_ZERO);
        raw1     = useRs1 && (rs1Addr != REG_ZERO) && busy[rs1Addr] &&
                   !(BYPASS && wb_en && (rdAddr == rs1Addr));
        raw2     = useRs2 && (rs2Addr != REG_ZERO) && busy[rs2Addr] &&
                   !(BYPASS && wb_en && (rdAddr == rs2Addr));
        waw      = issueValid && (issueRd != REG_ZERO) && busy[issueRd] &&
                   !(wb_en && (rdAddr == issueRd));
        stall    = raw1 || raw2 || waw;
        issue_en = issueValid && !stall && (issueRd != REG_ZERO);
    end

    // Next busy vector: writeback clears, accepted issue sets, set wins on the same rd.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_en) begin
            set_vec[issueRd] = 1'b1;
        end
        if (wb_en) begin
            clr_vec[rdAddr] = 1'b1;
        end
        busy_nxt = (busy & ~clr_vec) | set_vec;
        cnt_nxt  = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + BUSY_CNT_W'(busy_nxt[i]);
        end
    end

    // Busy state and its count move together so busyCount always matches busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            busyCount <= '0;
        end else begin
            busy      <= busy_nxt;
            busyCount <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two read ports, one write port and a pending-write scoreboard.
// Latency: reads combinational (optionally forwarding writeback), writes land at the next edge.
// Backpressure: stall asserted on RAW/WAW against an in-flight multi-cycle result.
module regfile_sb #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   rf
);
    import riscv_pkg::*;

    logic [XLEN-1:0] regs [NREGS];
    logic            fwd1;
    logic            fwd2;

    // Storage; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.we && (rf.rdAddr != REG_ZERO)) begin
            regs[rf.rdAddr] <= rf.rdData;
        end
    end

    // Read ports with optional writeback forwarding; forced to zero while reset is held
    // so a forwarded rdData cannot leak out during reset.
    always_comb begin
        fwd1  = BYPASS && rf.we && (rf.rdAddr == rf.rs1Addr);
        fwd2  = BYPASS && rf.we && (rf.rdAddr == rf.rs2Addr);
        rf.r1 = '0;
        rf.r2 = '0;
        if (rst_n) begin
            if (rf.rs1Addr != REG_ZERO) begin
                rf.r1 = fwd1 ? rf.rdData : regs[rf.rs1Addr];
            end
            if (rf.rs2Addr != REG_ZERO) begin
                rf.r2 = fwd2 ? rf.rdData : regs[rf.rs2Addr];
            end
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1Addr    (rf.rs1Addr),
        .rs2Addr    (rf.rs2Addr),
        .useRs1     (rf.useRs1),
        .useRs2     (rf.useRs2),
        .we         (rf.we),
        .rdAddr     (rf.rdAddr),
        .issueValid (rf.issueValid),
        .issueRd    (rf.issueRd),
        .stall      (rf.stall),
        .busyCount  (rf.busyCount)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance driven with identical stimulus.
// Latency: inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Backpressure: the reference model applies the stall rule to decide whether an issue lands.
`timescale 1ns/1ps
module tb_regfile_sb;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_addr_t   rs1, rs2, rd, ird;
    logic        u1, u2, we, iv;
    logic [31:0] wd;

    regfile_sb_if #(.XLEN(32)) ifn ();
    regfile_sb_if #(.XLEN(32)) ifb ();

    assign ifn.rs1Addr = rs1;  assign ifb.rs1Addr = rs1;
    assign ifn.rs2Addr = rs2;  assign ifb.rs2Addr = rs2;
    assign ifn.useRs1  = u1;   assign ifb.useRs1  = u1;
    assign ifn.useRs2  = u2;   assign ifb.useRs2  = u2;
    assign ifn.we      = we;   assign ifb.we      = we;
    assign ifn.rdAddr  = rd;   assign ifb.rdAddr  = rd;
    assign ifn.rdData  = wd;   assign ifb.rdData  = wd;
    assign ifn.issueValid = iv;  assign ifb.issueValid = iv;
    assign ifn.issueRd    = ird; assign ifb.issueRd    = ird;

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_nob (.clk(clk), .rst_n(rst_n), .rf(ifn));
    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_byp (.clk(clk), .rst_n(rst_n), .rf(ifb));

    // Index 0 = no bypass instance, 1 = bypass instance.
    logic [31:0] r1o [2];
    logic [31:0] r2o [2];
    logic        sto [2];
    logic [5:0]  bco [2];
    assign r1o[0] = ifn.r1;        assign r1o[1] = ifb.r1;
    assign r2o[0] = ifn.r2;        assign r2o[1] = ifb.r2;
    assign sto[0] = ifn.stall;     assign sto[1] = ifb.stall;
    assign bco[0] = ifn.busyCount; assign bco[1] = ifb.busyCount;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural values and the set of pending registers.
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, reg_addr_t a);
        if (a == 5'd0) return 32'd0;
        if (k == 1 && we && rd == a) return wd;
        return m_reg[k][a];
    endfunction

    function automatic bit exp_stall(int k);
        bit s;
        s = 1'b0;
        if (u1 && m_busy[k][rs1] && !(k == 1 && we && rd == rs1)) s = 1'b1;
        if (u2 && m_busy[k][rs2] && !(k == 1 && we && rd == rs2)) s = 1'b1;
        if (iv && m_busy[k][ird] && !(we && rd == ird)) s = 1'b1;
        return s;
    endfunction

    function automatic int exp_cnt(int k);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
        return c;
    endfunction

    // Model state advances on the same edge the DUT does.
    always @(posedge clk or negedge rst_n) begin
        bit st;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 32; i++) begin
                    m_reg[k][i]  = 32'd0;
                    m_busy[k][i] = 1'b0;
                end
        end else begin
            for (int k = 0; k < 2; k++) begin
                st = exp_stall(k);
                if (we && rd != 5'd0) begin
                    m_reg[k][rd]  = wd;
                    m_busy[k][rd] = 1'b0;
                end
                if (iv && !st && ird != 5'd0) m_busy[k][ird] = 1'b1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk($sformatf("rst_r1[%0d]", k), r1o[k], 0);
                chk($sformatf("rst_r2[%0d]", k), r2o[k], 0);
                chk($sformatf("rst_stall[%0d]", k), sto[k], 0);
                chk($sformatf("rst_bc[%0d]", k), bco[k], 0);
            end else begin
                chk($sformatf("cmp_r1[%0d]", k), r1o[k], exp_rd(k, rs1));
                chk($sformatf("cmp_r2[%0d]", k), r2o[k], exp_rd(k, rs2));
                chk($sformatf("cmp_stall[%0d]", k), sto[k], exp_stall(k));
                chk($sformatf("cmp_bc[%0d]", k), bco[k], exp_cnt(k));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        // Busy-looking inputs while reset is held must have no visible effect.
        rs1 = '0; rs2 = '0; u1 = 1'b1; u2 = 1'b1;
        we = 1'b1; rd = 5'd5; wd = 32'hFFFF_FFFF; iv = 1'b1; ird = 5'd3;
        repeat (2) cyc();
        for (int i = 0; i < 32; i++) begin
            rs1 = reg_addr_t'(i);
            rs2 = reg_addr_t'(31 - i);
            rd  = reg_addr_t'(i);
            #1;
            chk("sweep_r1_byp", ifb.r1, 0);
            chk("sweep_r2_byp", ifb.r2, 0);
            chk("sweep_r1_nob", ifn.r1, 0);
            chk("sweep_stall", ifb.stall, 0);
        end
        u1 = 1'b0; u2 = 1'b0; we = 1'b0; iv = 1'b0; rs1 = '0; rs2 = '0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Plain write, then read next cycle; x0 writes are discarded.
        we = 1'b1; rd = 5'd3; wd = 32'hDEAD_BEEF;
        cyc();
        we = 1'b0; rs1 = 5'd3;
        mid();
        chk("x3_byp", ifb.r1, 32'hDEAD_BEEF);
        chk("x3_nob", ifn.r1, 32'hDEAD_BEEF);
        cyc();
        we = 1'b1; rd = 5'd0; wd = 32'h1234; rs1 = 5'd0;
        mid();
        chk("x0_same_byp", ifb.r1, 0);
        cyc();
        we = 1'b0;
        mid();
        chk("x0_next_byp", ifb.r1, 0);
        chk("x0_next_nob", ifn.r1, 0);

        // Forwarding versus next-cycle visibility.
        cyc();
        we = 1'b1; rd = 5'd7; wd = 32'h55; rs2 = 5'd7;
        mid();
        chk("fwd_r2_byp", ifb.r2, 32'h55);
        chk("fwd_r2_nob_old", ifn.r2, 0);
        cyc();
        we = 1'b0;
        mid();
        chk("fwd_r2_nob_new", ifn.r2, 32'h55);

        // RAW on a pending register, cleared by writeback.
        cyc();
        iv = 1'b1; ird = 5'd9;
        cyc();
        iv = 1'b0; u1 = 1'b1; rs1 = 5'd9;
        mid();
        chk("raw_stall_byp", ifb.stall, 1);
        chk("raw_stall_nob", ifn.stall, 1);
        chk("raw_bc_byp", ifb.busyCount, 1);
        cyc();
        we = 1'b1; rd = 5'd9; wd = 32'hA5;
        mid();
        chk("wb_stall_byp", ifb.stall, 0);
        chk("wb_r1_byp", ifb.r1, 32'hA5);
        chk("wb_stall_nob", ifn.stall, 1);
        chk("wb_r1_nob", ifn.r1, 0);
        cyc();
        we = 1'b0; u1 = 1'b0;
        mid();
        chk("wb_bc_byp", ifb.busyCount, 0);
        chk("wb_bc_nob", ifn.busyCount, 0);

        // WAW: re-issue to a busy register, then the same with a writeback.
        cyc();
        iv = 1'b1; ird = 5'd4;
        cyc();
        mid();
        chk("waw_stall", ifb.stall, 1);
        chk("waw_bc", ifb.busyCount, 1);
        cyc();
        mid();
        chk("waw_bc_hold", ifn.busyCount, 1);
        cyc();
        we = 1'b1; rd = 5'd4; wd = 32'h44;
        mid();
        chk("waw_wb_stall_byp", ifb.stall, 0);
        chk("waw_wb_stall_nob", ifn.stall, 0);
        cyc();
        iv = 1'b0; we = 1'b0; rs1 = 5'd4;
        mid();
        chk("waw_wb_x4", ifn.r1, 32'h44);
        chk("waw_wb_bc", ifb.busyCount, 1);
        cyc();
        we = 1'b1; rd = 5'd4; wd = 32'h45;
        cyc();
        we = 1'b0;

        // Issue to x0, then fill the scoreboard.
        iv = 1'b1; ird = 5'd0;
        mid();
        chk("iss_x0_stall", ifb.stall, 0);
        cyc();
        iv = 1'b0;
        mid();
        chk("iss_x0_bc", ifb.busyCount, 0);
        cyc();
        for (int i = 1; i < 32; i++) begin
            iv = 1'b1; ird = reg_addr_t'(i);
            cyc();
        end
        iv = 1'b0;
        mid();
        chk("fill_bc_byp", ifb.busyCount, 31);
        chk("fill_bc_nob", ifn.busyCount, 31);
        cyc();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; rd = reg_addr_t'(i); wd = $urandom;
            cyc();
        end
        we = 1'b0;
        mid();
        chk("drain_bc", ifb.busyCount, 0);

        // Asynchronous reset while x5 is written and pending.
        cyc();
        we = 1'b1; rd = 5'd5; wd = 32'h77;
        cyc();
        we = 1'b0; iv = 1'b1; ird = 5'd5;
        cyc();
        iv = 1'b0; u1 = 1'b1; rs1 = 5'd5;
        #1;
        chk("pre_rst_stall", ifb.stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_bc", ifb.busyCount, 0);
        chk("arst_r1_byp", ifb.r1, 0);
        chk("arst_r1_nob", ifn.r1, 0);
        chk("arst_stall", ifb.stall, 0);
        cyc();
        cyc();
        rst_n = 1'b1; u1 = 1'b0;
        cyc();

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                rs1 = reg_addr_t'($urandom_range(0, 31));
                rd  = reg_addr_t'($urandom_range(0, 31));
            end else begin
                rs1 = reg_addr_t'($urandom_range(0, 7));
                rd  = reg_addr_t'($urandom_range(0, 7));
            end
            rs2 = reg_addr_t'($urandom_range(0, 7));
            ird = reg_addr_t'($urandom_range(0, 7));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            we  = ($urandom_range(0, 9) < 4);
            iv  = ($urandom_range(0, 9) < 4);
            wd  = $urandom;
            cyc();
        end
        u1 = 1'b0; u2 = 1'b0; we = 1'b0; iv = 1'b0;
        cyc();
        mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file with a pending-write scoreboard for the single-cycle RISC-V core.
- Supplies operands r1/r2 to the ALU and accepts aluOut (and later multi-cycle unit results) as writeback.
- Tracks registers whose value is still being produced by a multi-cycle unit and raises stall on RAW/WAW hazards.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; x0 is always included.
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to the read ports and can clear a stall.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1Addr  input  5  read port 1 address.
- rs2Addr  input  5  read port 2 address.
- useRs1  input  1  current instruction consumes rs1.
- useRs2  input  1  current instruction consumes rs2.
- r1  output  XLEN  read port 1 data, combinational.
- r2  output  XLEN  read port 2 data, combinational.
- we  input  1  writeback enable.
- rdAddr  input  5  writeback address.
- rdData  input  XLEN  writeback data (aluOut or multi-cycle result).
- issueValid  input  1  a multi-cycle op is issued this cycle; its destination becomes pending.
- issueRd  input  5  destination of the issued op.
- stall  output  1  hazard detected; the issue stage must hold.
- busyCount  output  6  number of currently pending registers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0, all busy bits clear to 0, busyCount is 0.
  - r1/r2 read as 0 and stall is 0 while reset is held.
- x0:
  - Always reads 0.
  - Writes to x0 are discarded.
  - Issue to x0 sets no busy bit.
  - x0 never causes a stall.
- Write:
  - If we=1 and rdAddr≠0, reg[rdAddr] ← rdData at the rising edge.
  - The written register's busy bit clears at the same edge.
- Read:
  - r1 = reg[rs1Addr] combinationally; r2 likewise.
  - With BYPASS=1, if we=1 and rdAddr=rs1Addr≠0, then r1 = rdData in the same cycle; r2 likewise.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Issue:
  - If issueValid=1, stall=0 and issueRd≠0, busy[issueRd] ← 1 at the edge.
  - An issue blocked by stall has no effect.
- Simultaneous issue and writeback to the same rd:
  - The register takes rdData.
  - The busy bit ends set, because the new issue wins.
- Stall is combinational, the OR of:
  - RAW on rs1: useRs1 & busy[rs1Addr] & ¬(BYPASS & we & rdAddr=rs1Addr).
  - RAW on rs2: the same term for rs2.
  - WAW: issueValid & busy[issueRd] & ¬(we & rdAddr=issueRd).
- busyCount:
  - Registered popcount of the busy bits, updated each edge.
  - Range 0..31, cannot overflow.
- Reset mid-operation: all pending state is lost. Outstanding multi-cycle units must also be reset by the same rst_n.
- Writeback to a register that is not busy is legal: data is written and the busy bit stays 0.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN=32 and REG_ADDR_W=5.
  - The REG_ZERO constant.
  - The typedef reg_addr_t (logic [4:0]).
- Natural sub-module: reg_scoreboard.
  - Holds the busy bit vector and busyCount.
  - Generates the set/clear terms and the WAW/RAW stall logic.
- regfile_sb owns the storage array and the read/bypass muxes.

Test Plan:
- Reset → r1=r2=0 for all addresses, stall=0, busyCount=0. Assert rst_n low mid-run with x5 busy → busy cleared and reg x5=0 immediately (asynchronous).
- Write x3=0xDEADBEEF, then read rs1Addr=3 next cycle → r1=0xDEADBEEF. Write x0=0x1234 → r1 at rs1Addr=0 stays 0.
- BYPASS=1: same cycle we=1, rdAddr=7, rdData=0x55, rs2Addr=7 → r2=0x55 in that cycle. With BYPASS=0 → r2 shows the old value, then 0x55 next cycle.
- Issue rd=9. Next cycle useRs1=1, rs1Addr=9 → stall=1 and busyCount=1. Writeback x9=0xA5 with BYPASS=1 → stall=0 that cycle, r1=0xA5, busyCount=0 next cycle.
- Issue rd=4 while x4 is busy and there is no writeback → stall=1 (WAW) and busyCount unchanged. Same case with a writeback to x4 in that cycle → stall=0, x4 written, busy[4] remains 1.
- Issue rd=0 → no busy bit set, busyCount stays 0, stall=0. Issue x1..x31 sequentially → busyCount=31.
